// File: rtl/lieat_axi_mst.sv
// Single-outstanding AXI initiator: bridges a valid/ready memory request port onto AR/R/AW/W/B.
// Optional: define LIEAT_AXI_MST_ALIGN_CHK_EN to reject misaligned requests at accept.
`ifndef XLEN
`define XLEN 32
`endif

module lieat_axi_mst #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned ID_W    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [`XLEN-1:0]      req_addr,
    input  logic [2:0]            req_size,
    input  logic [`XLEN*2-1:0]    req_wdata,
    input  logic [ID_W-1:0]       req_id,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [`XLEN*2-1:0]    rsp_rdata,
    output logic                  rsp_err,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [`XLEN-1:0]      axi_araddr,
    output logic [2:0]            axi_arsize,
    output logic [ID_W-1:0]       axi_arid,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    input  logic [`XLEN*2-1:0]    axi_rdata,
    input  logic [ID_W-1:0]       axi_rid,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [`XLEN-1:0]      axi_awaddr,
    output logic [2:0]            axi_awsize,
    output logic [ID_W-1:0]       axi_awid,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    output logic [`XLEN*2-1:0]    axi_wdata,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    input  logic [1:0]            axi_bresp,
    input  logic [ID_W-1:0]       axi_bid
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {StIdle, StAr, StRWait, StAwW, StBWait, StRsp} state_e;

    state_e               state_q;
    logic                 req_ready_q;
    logic                 arvalid_q, awvalid_q, wvalid_q;
    logic                 rready_q, bready_q;
    logic                 aw_done_q, w_done_q;
    logic                 rsp_valid_q, rsp_err_q;
    logic [`XLEN*2-1:0]   rsp_rdata_q;
    logic [`XLEN-1:0]     addr_q;
    logic [2:0]           size_q;
    logic [ID_W-1:0]      id_q;
    logic [`XLEN*2-1:0]   wdata_q;
    logic [CNT_W-1:0]     cnt_q;

    logic req_bad, timeout_hit, aw_hs, w_hs, aw_fin, w_fin;
    logic unused_bid;

    // bid is deliberately not checked against the request ID.
    assign unused_bid = ^axi_bid;

`ifdef LIEAT_AXI_MST_ALIGN_CHK_EN
    logic [2:0] align_mask;
    always_comb begin
        align_mask = 3'b000;
        case (req_size)
            3'd1:    align_mask = 3'b001;
            3'd2:    align_mask = 3'b011;
            3'd3:    align_mask = 3'b111;
            default: align_mask = 3'b000;
        endcase
        req_bad = (req_size > 3'd3) || ((req_addr[2:0] & align_mask) != 3'b000);
    end
`else
    always_comb begin
        req_bad = (req_size > 3'd3);
    end
`endif

    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
        aw_hs       = awvalid_q && axi_awready;
        w_hs        = wvalid_q && axi_wready;
        aw_fin      = aw_done_q || aw_hs;
        w_fin       = w_done_q || w_hs;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            id_q        <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            // Always sink R/B so stray or late beats never stall the responder.
            rready_q <= 1'b1;
            bready_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        size_q      <= req_size;
                        id_q        <= req_id;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        if (req_bad) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            state_q     <= StRsp;
                        end else if (req_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= StAwW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= StAr;
                        end
                    end
                end
                StAr: begin
                    if (axi_arready) begin
                        arvalid_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= StRWait;
                    end
                end
                StRWait: begin
                    if (axi_rvalid && rready_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= (axi_rid != id_q);
                        rsp_rdata_q <= (axi_rid != id_q) ? '0 : axi_rdata;
                        state_q     <= StRsp;
                    end else if (timeout_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= StRsp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StAwW: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        cnt_q   <= '0;
                        state_q <= StBWait;
                    end
                end
                StBWait: begin
                    if (axi_bvalid && bready_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= axi_bresp[1];
                        state_q     <= StRsp;
                    end else if (timeout_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= StRsp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRsp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = addr_q;
    assign axi_arsize  = size_q;
    assign axi_arid    = id_q;
    assign axi_rready  = rready_q;
    assign axi_awvalid = awvalid_q;
    assign axi_awaddr  = addr_q;
    assign axi_awsize  = size_q;
    assign axi_awid    = id_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_bready  = bready_q;

endmodule

// File: tb/tb_lieat_axi_mst.sv
// Randomized bench for lieat_axi_mst: a cycle-driven AXI responder plus a transaction-level
// expectation (response value, error and latency) computed from the bridge's rules.
`ifndef XLEN
`define XLEN 32
`endif

module tb_lieat_axi_mst;

    localparam int unsigned TMO = 8;
`ifdef LIEAT_AXI_MST_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 req_valid, req_ready, req_write;
    logic [`XLEN-1:0]     req_addr;
    logic [2:0]           req_size;
    logic [`XLEN*2-1:0]   req_wdata;
    logic [3:0]           req_id;
    logic                 rsp_valid, rsp_ready, rsp_err;
    logic [`XLEN*2-1:0]   rsp_rdata;
    logic                 axi_arvalid, axi_arready;
    logic [`XLEN-1:0]     axi_araddr;
    logic [2:0]           axi_arsize;
    logic [3:0]           axi_arid;
    logic                 axi_rvalid, axi_rready;
    logic [`XLEN*2-1:0]   axi_rdata;
    logic [3:0]           axi_rid;
    logic                 axi_awvalid, axi_awready;
    logic [`XLEN-1:0]     axi_awaddr;
    logic [2:0]           axi_awsize;
    logic [3:0]           axi_awid;
    logic                 axi_wvalid, axi_wready;
    logic [`XLEN*2-1:0]   axi_wdata;
    logic                 axi_bvalid, axi_bready;
    logic [1:0]           axi_bresp;
    logic [3:0]           axi_bid;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    lieat_axi_mst #(.TIMEOUT(TMO), .ID_W(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_id(req_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arsize(axi_arsize), .axi_arid(axi_arid),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rid(axi_rid),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awsize(axi_awsize), .axi_awid(axi_awid),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_bid(axi_bid)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic axi_idle();
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rid = '0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = '0; axi_bid = '0;
    endtask

    // rsp_dly >= TMO means the responder stays silent until after the response (late beat).
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [63:0] wdata, input logic [3:0] id,
                           input logic [63:0] rd, input int ar_dly, input int aw_dly,
                           input int w_dly, input int rsp_dly, input bit bad_id,
                           input logic [1:0] bresp, input int hold);
        bit          bad_req, timed_out, r_arm, b_arm, aw_got, w_got;
        int          lat, ar_seen, aw_seen, w_seen, r_cnt, b_cnt;
        int          n_ar, n_aw, n_w, n_r, n_b, exp_lat, mx;
        logic        exp_err;
        logic [63:0] exp_data, held;

        bad_req = (size > 3'd3) ||
                  (ALIGN_CHK && ((addr & ((32'd1 << size) - 32'd1)) != 32'd0));
        mx = (aw_dly > w_dly) ? aw_dly : w_dly;
        timed_out = 1'b0;
        if (bad_req) begin
            exp_err = 1'b1; exp_data = '0; exp_lat = 1;
        end else if (rsp_dly >= int'(TMO)) begin
            timed_out = 1'b1;
            exp_err = 1'b1; exp_data = '0;
            exp_lat = 2 + (wr ? mx : ar_dly) + int'(TMO);
        end else if (wr) begin
            exp_err = bresp[1]; exp_data = '0; exp_lat = 3 + mx + rsp_dly;
        end else begin
            exp_err = bad_id; exp_data = bad_id ? 64'd0 : rd; exp_lat = 3 + ar_dly + rsp_dly;
        end

        check_eq("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
        req_wdata = wdata; req_id = id; rsp_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = {$urandom, $urandom};
        lat = 1; ar_seen = 0; aw_seen = 0; w_seen = 0; r_cnt = 0; b_cnt = 0;
        n_ar = 0; n_aw = 0; n_w = 0; n_r = 0; n_b = 0;
        r_arm = 0; b_arm = 0; aw_got = 0; w_got = 0;
        while (!rsp_valid && lat < 80) begin
            axi_idle();
            axi_arready = axi_arvalid && (ar_seen == ar_dly);
            axi_awready = axi_awvalid && (aw_seen == aw_dly);
            axi_wready  = axi_wvalid && (w_seen == w_dly);
            if (r_arm && r_cnt == rsp_dly) begin
                axi_rvalid = 1'b1; axi_rdata = rd; axi_rid = bad_id ? id + 4'd1 : id;
                r_arm = 0; n_r++;
                check_eq("rready", axi_rready, 1'b1);
            end
            if (b_arm && b_cnt == rsp_dly) begin
                axi_bvalid = 1'b1; axi_bresp = bresp; axi_bid = id;
                b_arm = 0; n_b++;
                check_eq("bready", axi_bready, 1'b1);
            end
            if (r_arm) r_cnt++;
            if (b_arm) b_cnt++;
            if (axi_arvalid) ar_seen++;
            if (axi_awvalid) aw_seen++;
            if (axi_wvalid) w_seen++;
            if (axi_arready) begin
                n_ar++; r_arm = 1; r_cnt = 0;
                check_eq("araddr", axi_araddr, addr);
                check_eq("ar_size_id", {axi_arsize, axi_arid}, {size, id});
            end
            if (axi_awready) begin
                n_aw++; aw_got = 1;
                check_eq("awaddr", axi_awaddr, addr);
                check_eq("aw_size_id", {axi_awsize, axi_awid}, {size, id});
            end
            if (axi_wready) begin
                n_w++; w_got = 1;
                check_eq("wdata", axi_wdata, wdata);
            end
            if (aw_got && w_got && (axi_awready || axi_wready)) begin
                b_arm = 1; b_cnt = 0;
            end
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
        axi_idle();

        check_eq("rsp_valid", rsp_valid, 1'b1);
        check_eq("latency", lat, exp_lat);
        check_eq("rsp_err", rsp_err, exp_err);
        check_eq("rsp_rdata", rsp_rdata, exp_data);
        check_eq("req_ready_busy", req_ready, 1'b0);
        check_eq("ar_hs_count", n_ar, (!bad_req && !wr) ? 1 : 0);
        check_eq("aw_w_hs_count", {n_aw, n_w}, (!bad_req && wr) ? {32'd1, 32'd1} : 64'd0);

        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            check_eq("hold_state", {rsp_valid, rsp_err, req_ready}, {1'b1, exp_err, 1'b0});
            check_eq("hold_rdata", rsp_rdata, held);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        check_eq("post_rsp", {rsp_valid, req_ready}, 2'b01);

        if (timed_out) begin
            // Late beat lands in IDLE and must vanish without a response.
            if (wr) begin
                axi_bvalid = 1'b1; axi_bresp = 2'b00; axi_bid = id;
            end else begin
                axi_rvalid = 1'b1; axi_rdata = rd; axi_rid = id;
            end
            @(posedge clock);
            @(negedge clock);
            axi_idle();
            check_eq("late_beat_dropped", {rsp_valid, req_ready}, 2'b01);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
        req_wdata = '0; req_id = '0; rsp_ready = 1'b0;
        axi_idle();
        #12;
        check_eq("rst_req_ready", req_ready, 1'b1);
        check_eq("rst_valids", {axi_arvalid, axi_awvalid, axi_wvalid, rsp_valid}, 4'b0);
        check_eq("rst_readies", {axi_rready, axi_bready}, 2'b00);
        check_eq("rst_rsp", {rsp_err, rsp_rdata}, 65'd0);
        check_eq("rst_regs", {axi_araddr, axi_arsize, axi_arid, axi_wdata}, 103'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_eq("readies_up", {axi_rready, axi_bready}, 2'b11);

        // Directed scenarios
        run_txn(0, 32'h8000_0010, 3, 64'd0, 4'd3, 64'h1122_3344_5566_7788,
                0, 0, 0, 0, 0, 2'b00, 0);
        run_txn(1, 32'h8000_0020, 2, 64'hdead_beef, 4'd5, 64'd0, 0, 0, 2, 0, 0, 2'b01, 0);
        run_txn(0, 32'h8000_0040, 2, 64'd0, 4'd2, 64'h0bad_0bad_0bad_0bad,
                0, 0, 0, 1, 1, 2'b00, 0);
        run_txn(0, 32'h8000_0048, 3, 64'd0, 4'd2, 64'h0123_4567_89ab_cdef,
                1, 0, 0, 0, 0, 2'b00, 0);
        run_txn(0, 32'h8000_0050, 3, 64'd0, 4'd7, 64'h5555_aaaa_5555_aaaa,
                0, 0, 0, 20, 0, 2'b00, 0);
        run_txn(0, 32'h8000_0058, 3, 64'd0, 4'd7, 64'h7777_0000_7777_0000,
                0, 0, 0, TMO - 1, 0, 2'b00, 0);
        run_txn(1, 32'h8000_0060, 3, 64'h1, 4'd1, 64'd0, 0, 1, 1, 20, 0, 2'b00, 0);
        run_txn(1, 32'h8000_0068, 3, 64'h2, 4'd1, 64'd0, 0, 0, 0, 0, 0, 2'b10, 0);
        run_txn(0, 32'h8000_0070, 4, 64'd0, 4'd4, 64'd0, 0, 0, 0, 0, 0, 2'b00, 0);
        run_txn(1, 32'h8000_0072, 2, 64'h3, 4'd4, 64'd0, 0, 0, 0, 0, 0, 2'b00, 0);
        run_txn(0, 32'h8000_0078, 3, 64'd0, 4'd9, 64'hfeed_face_cafe_f00d,
                0, 0, 0, 0, 0, 2'b00, 5);

        // Reset mid-write: valids must drop immediately, asynchronously.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0100; req_size = 3'd2;
        req_wdata = 64'h1234; req_id = 4'd6;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_eq("aw_w_pending", {axi_awvalid, axi_wvalid}, 2'b11);
        #1 reset = 1'b1;
        #1;
        check_eq("async_rst_valids", {axi_arvalid, axi_awvalid, axi_wvalid, rsp_valid}, 4'b0);
        check_eq("async_rst_req_ready", req_ready, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_eq("after_rst_req_ready", req_ready, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            sz = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            a = 32'h8000_0000 | ($urandom & 32'h0000_fff8);
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 7));
            run_txn(1'($urandom_range(0, 1)), a, sz, {$urandom, $urandom},
                    4'($urandom_range(0, 15)), {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0) ? int'(TMO) + 3 : $urandom_range(0, 4),
                    ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
